// File: rtl/riscv_definitions.sv
// Shared definitions for the instruction/data memory-port arbiter.
package riscv_definitions;

  localparam int unsigned ARB_DATA_MAX_STREAK = 4;
  localparam logic [3:0]  ARB_BE_WORD         = 4'b1111;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_INST_WAIT,
    ARB_DATA_WAIT,
    ARB_RESP
  } arb_state_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side signals of the fetch/data memory-port arbiter.
interface mem_port_arbiter_if;
  logic        i_inst_rd_en;
  logic [31:0] i_inst_addr;
  logic        i_inst_kill;
  logic        o_instr_ready;
  logic [31:0] o_instr_data;
  logic        i_data_rd_en_ma;
  logic        i_data_wr_en_ma;
  logic [31:0] i_data_addr;
  logic [31:0] i_data_wr;
  logic [3:0]  i_data_rd_en_ctrl;
  logic        o_data_ready;
  logic [31:0] o_data_rd;
  logic        o_mem_req;
  logic        o_mem_we;
  logic [31:0] o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic [3:0]  o_mem_be;
  logic        i_mem_ack;
  logic [31:0] i_mem_rdata;

  // Arbiter side.
  modport slave (
    input  i_inst_rd_en, i_inst_addr, i_inst_kill,
    input  i_data_rd_en_ma, i_data_wr_en_ma, i_data_addr, i_data_wr, i_data_rd_en_ctrl,
    input  i_mem_ack, i_mem_rdata,
    output o_instr_ready, o_instr_data, o_data_ready, o_data_rd,
    output o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_be
  );

  // Requesters plus memory, as seen from outside the arbiter.
  modport master (
    output i_inst_rd_en, i_inst_addr, i_inst_kill,
    output i_data_rd_en_ma, i_data_wr_en_ma, i_data_addr, i_data_wr, i_data_rd_en_ctrl,
    output i_mem_ack, i_mem_rdata,
    input  o_instr_ready, o_instr_data, o_data_ready, o_data_rd,
    input  o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_be
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and load/store,
// one transaction at a time, with a bounded data-over-fetch priority streak.
module mem_port_arbiter
  import riscv_definitions::*;
#(
  parameter int unsigned DATA_MAX_STREAK = ARB_DATA_MAX_STREAK
) (
  input logic               clk,
  input logic               rst_n,
  mem_port_arbiter_if.slave bus
);

  localparam int unsigned    CW         = (DATA_MAX_STREAK > 0) ? $clog2(DATA_MAX_STREAK + 1) : 1;
  localparam logic [CW-1:0]  STREAK_MAX = CW'(DATA_MAX_STREAK);

  arb_state_t    state_q, state_d;
  logic [CW-1:0] streak_q, streak_d;
  logic          discard_q, discard_d;
  logic          served_inst_q, served_inst_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [3:0]    be_q, be_d;
  logic          we_q, we_d;
  logic [31:0]   instr_q, instr_d;
  logic [31:0]   rd_q, rd_d;

  logic data_req;
  logic fetch_wins;

  always_comb begin
    state_d       = state_q;
    streak_d      = streak_q;
    discard_d     = discard_q;
    served_inst_d = served_inst_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    be_d          = be_q;
    we_d          = we_q;
    instr_d       = instr_q;
    rd_d          = rd_q;

    data_req   = bus.i_data_rd_en_ma | bus.i_data_wr_en_ma;
    // Fetch only overtakes a pending data request once the streak is exhausted.
    fetch_wins = bus.i_inst_rd_en && (!data_req || (streak_q == STREAK_MAX));

    unique case (state_q)
      ARB_IDLE: begin
        if (fetch_wins) begin
          state_d       = ARB_INST_WAIT;
          served_inst_d = 1'b1;
          addr_d        = bus.i_inst_addr;
          we_d          = 1'b0;
          be_d          = ARB_BE_WORD;
          streak_d      = '0;
        end else if (data_req) begin
          state_d       = ARB_DATA_WAIT;
          served_inst_d = 1'b0;
          addr_d        = bus.i_data_addr;
          wdata_d       = bus.i_data_wr;
          be_d          = bus.i_data_rd_en_ctrl;
          we_d          = bus.i_data_wr_en_ma;
          if (!bus.i_inst_rd_en)
            streak_d = '0;
          else if (streak_q != STREAK_MAX)
            streak_d = streak_q + 1'b1;
        end
      end
      ARB_INST_WAIT: begin
        discard_d = discard_q | bus.i_inst_kill;
        if (bus.i_mem_ack) begin
          state_d = ARB_RESP;
          if (!(discard_q | bus.i_inst_kill))
            instr_d = bus.i_mem_rdata;
        end
      end
      ARB_DATA_WAIT: begin
        if (bus.i_mem_ack) begin
          state_d = ARB_RESP;
          if (!we_q)
            rd_d = bus.i_mem_rdata;
        end
      end
      ARB_RESP: begin
        state_d   = ARB_IDLE;
        discard_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ARB_IDLE;
      streak_q      <= '0;
      discard_q     <= 1'b0;
      served_inst_q <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      be_q          <= '0;
      we_q          <= 1'b0;
      instr_q       <= '0;
      rd_q          <= '0;
    end else begin
      state_q       <= state_d;
      streak_q      <= streak_d;
      discard_q     <= discard_d;
      served_inst_q <= served_inst_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      be_q          <= be_d;
      we_q          <= we_d;
      instr_q       <= instr_d;
      rd_q          <= rd_d;
    end
  end

  assign bus.o_mem_req     = (state_q == ARB_INST_WAIT) || (state_q == ARB_DATA_WAIT);
  assign bus.o_mem_we      = we_q;
  assign bus.o_mem_addr    = addr_q;
  assign bus.o_mem_wdata   = wdata_q;
  assign bus.o_mem_be      = be_q;
  assign bus.o_instr_ready = (state_q == ARB_RESP) && served_inst_q && !discard_q;
  assign bus.o_instr_data  = instr_q;
  assign bus.o_data_ready  = (state_q == ARB_RESP) && !served_inst_q;
  assign bus.o_data_rd     = rd_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed scenarios then random traffic.
module tb_mem_port_arbiter;

  localparam int unsigned MAXS = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if bus();

  mem_port_arbiter #(.DATA_MAX_STREAK(MAXS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] exp_inst_q[$];
  logic [31:0] exp_data_q[$];
  logic [31:0] last_inst = '0;
  logic [31:0] last_rd   = '0;
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] dut_mem [logic [31:0]];
  int          ack_delay = 0;
  int unsigned streak_m  = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [31:0] mem_init(input logic [31:0] a);
    if (a == 32'h100)  return 32'h00500093;
    if (a == 32'h1200) return 32'h12345678;
    return {a[15:0], ~a[15:0]} ^ 32'h3C5A0F96;
  endfunction

  function automatic logic [31:0] apply_be(input logic [31:0] old, input logic [31:0] nw,
                                           input logic [3:0] be);
    logic [31:0] r = old;
    for (int i = 0; i < 4; i++)
      if (be[i]) r[8*i +: 8] = nw[8*i +: 8];
    return r;
  endfunction

  function automatic logic [31:0] ref_val(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : mem_init(a);
  endfunction

  // Requester signals as seen by the next rising edge.
  logic        snap_inst, snap_data, snap_we;
  logic [31:0] snap_iaddr, snap_daddr, snap_wd;
  logic [3:0]  snap_be;

  initial forever begin
    @(negedge clk);
    snap_inst  = bus.i_inst_rd_en;
    snap_data  = bus.i_data_rd_en_ma | bus.i_data_wr_en_ma;
    snap_we    = bus.i_data_wr_en_ma;
    snap_iaddr = bus.i_inst_addr;
    snap_daddr = bus.i_data_addr;
    snap_wd    = bus.i_data_wr;
    snap_be    = bus.i_data_rd_en_ctrl;
    if (bus.o_instr_ready && bus.o_data_ready)
      check("ready_overlap", 128'(bus.o_data_ready), 128'(0));
    if (bus.o_instr_ready) begin
      if (exp_inst_q.size() == 0) check("instr_ready_unexpected", 128'(bus.o_instr_ready), 128'(0));
      else check("instr_data", 128'(bus.o_instr_data), 128'(exp_inst_q.pop_front()));
    end
    if (bus.o_data_ready) begin
      if (exp_data_q.size() == 0) check("data_ready_unexpected", 128'(bus.o_data_ready), 128'(0));
      else check("data_rd", 128'(bus.o_data_rd), 128'(exp_data_q.pop_front()));
    end
  end

  // Memory model: acks after a programmable delay and checks grant decisions.
  logic        in_txn = 1'b0;
  logic        unstable;
  int          wait_cnt;
  logic [31:0] la, lw;
  logic [3:0]  lb;
  logic        lwe;
  logic        exp_is_data, pend_ok;

  initial begin
    bus.i_mem_ack   = 1'b0;
    bus.i_mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      if (bus.i_mem_ack || !bus.o_mem_req) begin
        if (bus.i_mem_ack && in_txn) check("mem_stable", 128'(unstable), 128'(0));
        bus.i_mem_ack = 1'b0;
        in_txn        = 1'b0;
      end else begin
        if (!in_txn) begin
          in_txn   = 1'b1;
          unstable = 1'b0;
          la = bus.o_mem_addr; lw = bus.o_mem_wdata; lb = bus.o_mem_be; lwe = bus.o_mem_we;
          wait_cnt = (ack_delay >= 0) ? ack_delay : int'($urandom_range(0, 3));
          pend_ok = 1'b1;
          exp_is_data = 1'b0;
          if (snap_data && !(snap_inst && streak_m == MAXS)) begin
            exp_is_data = 1'b1;
            streak_m = snap_inst ? ((streak_m < MAXS) ? streak_m + 1 : MAXS) : 0;
          end else if (snap_inst) begin
            streak_m = 0;
          end else pend_ok = 1'b0;
          if (!pend_ok)
            check("grant_spurious", 128'(bus.o_mem_req), 128'(0));
          else if (exp_is_data)
            check("grant_data", 128'({bus.o_mem_addr, bus.o_mem_we, bus.o_mem_be, bus.o_mem_wdata}),
                  128'({snap_daddr, snap_we, snap_be, snap_wd}));
          else
            check("grant_fetch", 128'({bus.o_mem_addr, bus.o_mem_we, bus.o_mem_be}),
                  128'({snap_iaddr, 1'b0, 4'hF}));
        end else if ({bus.o_mem_addr, bus.o_mem_wdata, bus.o_mem_be, bus.o_mem_we} !== {la, lw, lb, lwe}) begin
          unstable = 1'b1;
        end
        if (wait_cnt == 0) begin
          bus.i_mem_ack   = 1'b1;
          bus.i_mem_rdata = dut_mem.exists(la) ? dut_mem[la] : mem_init(la);
          if (lwe) dut_mem[la] = apply_be(bus.i_mem_rdata, lw, lb);
        end else wait_cnt--;
      end
    end
  end

  task automatic wait_ready(input bit inst, output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!(inst ? bus.o_instr_ready : bus.o_data_ready) && lat < 300);
    if (!(inst ? bus.o_instr_ready : bus.o_data_ready))
      check(inst ? "instr_timeout" : "data_timeout", 128'(0), 128'(1));
  endtask

  task automatic wait_mem_req(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.o_mem_req && n < 50);
    if (!bus.o_mem_req) check(name, 128'(bus.o_mem_req), 128'(1));
  endtask

  // Called just after a rising edge; returns just after a rising edge.
  task automatic do_fetch(input logic [31:0] a, output int lat);
    bus.i_inst_addr  = a;
    bus.i_inst_rd_en = 1'b1;
    exp_inst_q.push_back(mem_init(a));
    last_inst = mem_init(a);
    wait_ready(1'b1, lat);
    @(posedge clk); #1;
    bus.i_inst_rd_en = 1'b0;
  endtask

  task automatic do_data(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] be, output int lat);
    bus.i_data_addr       = a;
    bus.i_data_wr         = wd;
    bus.i_data_rd_en_ctrl = be;
    bus.i_data_rd_en_ma   = rd;
    bus.i_data_wr_en_ma   = wr;
    if (wr) begin
      ref_mem[a] = apply_be(ref_val(a), wd, be);
      exp_data_q.push_back(last_rd);
    end else begin
      last_rd = ref_val(a);
      exp_data_q.push_back(last_rd);
    end
    wait_ready(1'b0, lat);
    @(posedge clk); #1;
    bus.i_data_rd_en_ma = 1'b0;
    bus.i_data_wr_en_ma = 1'b0;
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) @(posedge clk);
    if (n > 0) #1;
  endtask

  int lat_a, lat_b;

  initial begin
    bus.i_inst_rd_en = 0; bus.i_inst_addr = '0; bus.i_inst_kill = 0;
    bus.i_data_rd_en_ma = 0; bus.i_data_wr_en_ma = 0; bus.i_data_addr = '0;
    bus.i_data_wr = '0; bus.i_data_rd_en_ctrl = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_mem_side", 128'({bus.o_mem_req, bus.o_mem_we, bus.o_mem_addr, bus.o_mem_wdata, bus.o_mem_be}), 128'(0));
    check("reset_req_side", 128'({bus.o_instr_ready, bus.o_instr_data, bus.o_data_ready, bus.o_data_rd}), 128'(0));

    // Lone fetch at 0x100, ack three cycles after request; granted on first edge after reset.
    rst_n = 1'b1;
    ack_delay = 3;
    do_fetch(32'h100, lat_a);
    check("fetch_latency_ack3", 128'(lat_a), 128'(6));

    ack_delay = 0;
    do_fetch(32'h1004, lat_a);
    check("fetch_latency_min", 128'(lat_a), 128'(3));

    // Simultaneous fetch and load: load first, fetch granted three cycles later.
    fork
      do_data(1'b1, 1'b0, 32'h2000, 32'h0, 4'hF, lat_a);
      do_fetch(32'h1008, lat_b);
    join
    check("collide_data_latency", 128'(lat_a), 128'(3));
    check("collide_fetch_latency", 128'(lat_b), 128'(6));

    // Partial store then read back.
    do_data(1'b0, 1'b1, 32'h40, 32'hDEADBEEF, 4'b0011, lat_a);
    check("store_latency", 128'(lat_a), 128'(3));
    do_data(1'b1, 1'b1, 32'h44, 32'hCAFEF00D, 4'b1100, lat_a);
    do_data(1'b1, 1'b0, 32'h40, 32'h0, 4'hF, lat_a);
    do_data(1'b1, 1'b0, 32'h44, 32'h0, 4'hF, lat_a);

    // Data streak with a fetch pending: the fetch becomes the fifth grant.
    fork
      do_fetch(32'h100C, lat_b);
      for (int i = 0; i < 6; i++) do_data(1'b1, 1'b0, 32'h2100 + 32'(4 * i), 32'h0, 4'hF, lat_a);
    join
    check("streak_fetch_latency", 128'(lat_b), 128'(15));

    // Kill during INST_WAIT discards the response.
    ack_delay = 3;
    bus.i_inst_addr  = 32'h1200;
    bus.i_inst_rd_en = 1'b1;
    wait_mem_req("kill_grant_timeout");
    @(posedge clk); #1;
    bus.i_inst_kill  = 1'b1;
    bus.i_inst_rd_en = 1'b0;
    @(posedge clk); #1;
    bus.i_inst_kill  = 1'b0;
    idle(10);
    check("kill_instr_data_kept", 128'(bus.o_instr_data), 128'(last_inst));
    do_fetch(32'h1010, lat_a);
    check("after_kill_fetch_latency", 128'(lat_a), 128'(6));

    // Kill while idle has no effect on the fetch granted that cycle.
    ack_delay = 1;
    fork
      do_fetch(32'h1014, lat_a);
      begin
        bus.i_inst_kill = 1'b1;
        @(posedge clk); #1;
        bus.i_inst_kill = 1'b0;
      end
    join
    check("idle_kill_fetch_latency", 128'(lat_a), 128'(4));

    // Reset in the middle of DATA_WAIT abandons the load.
    ack_delay = 10;
    bus.i_data_addr = 32'h2010; bus.i_data_rd_en_ctrl = 4'hF; bus.i_data_rd_en_ma = 1'b1;
    wait_mem_req("rst_grant_timeout");
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("rst_async_mem_side", 128'({bus.o_mem_req, bus.o_mem_we, bus.o_mem_addr, bus.o_mem_wdata, bus.o_mem_be}), 128'(0));
    check("rst_async_req_side", 128'({bus.o_instr_ready, bus.o_instr_data, bus.o_data_ready, bus.o_data_rd}), 128'(0));
    bus.i_data_rd_en_ma = 1'b0;
    streak_m = 0; last_rd = '0; last_inst = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(12);
    check("rst_no_late_req", 128'(bus.o_mem_req), 128'(0));
    ack_delay = 0;
    do_data(1'b1, 1'b0, 32'h2010, 32'h0, 4'hF, lat_a);
    check("post_rst_data_latency", 128'(lat_a), 128'(3));

    // Random traffic from both requesters.
    ack_delay = -1;
    fork
      for (int i = 0; i < 40; i++) begin
        idle($urandom_range(0, 3));
        do_fetch(32'h1000 + 32'($urandom_range(0, 1023) * 4), lat_a);
      end
      for (int j = 0; j < 60; j++) begin
        int unsigned op;
        idle($urandom_range(0, 3));
        op = $urandom_range(0, 2);
        do_data(op != 1, op != 0, 32'h2000 + 32'($urandom_range(0, 31) * 4), $urandom,
                4'($urandom_range(0, 15)), lat_b);
      end
    join
    idle(5);
    check("inst_queue_drained", 128'(exp_inst_q.size()), 128'(0));
    check("data_queue_drained", 128'(exp_data_q.size()), 128'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter: DATA_MAX_STREAK, default 4, max consecutive data grants while a fetch waits.
REQ-002 Ports (name direction width meaning):
- clk  in  1  sole clock; rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- i_inst_rd_en  in  1  fetch request.
- i_inst_addr  in  32  fetch address.
- i_inst_kill  in  1  discard in-flight fetch (pipeline flush).
- o_instr_ready  out  1  fetch response pulse.
- o_instr_data  out  32  fetched word.
- i_data_rd_en_ma  in  1  load request.
- i_data_wr_en_ma  in  1  store request.
- i_data_addr  in  32  load/store address.
- i_data_wr  in  32  store data.
- i_data_rd_en_ctrl  in  4  byte enables.
- o_data_ready  out  1  load/store completion pulse.
- o_data_rd  out  32  load word.
- o_mem_req  out  1  memory request.
- o_mem_we  out  1  write strobe.
- o_mem_addr  out  32  memory address.
- o_mem_wdata  out  32  write data.
- o_mem_be  out  4  byte enables.
- i_mem_ack  in  1  transfer complete; i_mem_rdata valid.
- i_mem_rdata  in  32  memory read data.

Function
REQ-003 The block SHALL share one single-port memory between the fetch and data requesters, one transaction at a time.
REQ-004 States SHALL be IDLE, INST_WAIT, DATA_WAIT and RESP.
REQ-005 Grants SHALL be issued in IDLE only.
REQ-006 IDLE priority SHALL be data over fetch, except when the streak counter equals DATA_MAX_STREAK and i_inst_rd_en=1; then fetch wins.
REQ-007 On a grant, the block SHALL register addr, wdata, be and we on that edge and enter the WAIT state.
REQ-008 o_mem_req SHALL be 1 throughout INST_WAIT/DATA_WAIT, with o_mem_addr/wdata/be/we stable until ack.
REQ-009 Data grant: we=i_data_wr_en_ma, be=i_data_rd_en_ctrl. If rd and wr are both asserted, the block SHALL perform a write.
REQ-010 Fetch grant: we=0, be=4'b1111, addr=i_inst_addr.
REQ-011 On i_mem_ack in WAIT, the block SHALL capture i_mem_rdata into o_instr_data (INST) or o_data_rd (data read only) and enter RESP.
REQ-012 In RESP, the served requester's ready SHALL pulse for exactly 1 cycle; the next state SHALL be IDLE.
REQ-013 Minimum latency: request in IDLE at cycle N, ack at N+1, ready at N+2, next grant at N+3.
REQ-014 Requesters SHALL hold their request and operands until ready; the arbiter does not re-sample them after the grant.
REQ-015 Streak counter: increments on a data grant when i_inst_rd_en=1, saturates at DATA_MAX_STREAK, and clears on any fetch grant or on a data grant with no fetch pending.
REQ-016 i_inst_kill in INST_WAIT (or on the ack cycle) SHALL set a discard flag; on ack, o_instr_ready stays 0 and o_instr_data is not updated; the flag clears in RESP.
REQ-017 i_inst_kill SHALL have no effect outside INST_WAIT.
REQ-018 An ack arriving in IDLE or RESP SHALL be ignored.
REQ-019 The block SHALL impose no timeout; WAIT persists until ack.

Reset
REQ-020 rst_n=0 SHALL asynchronously force state IDLE and clear the streak counter and discard flag.
REQ-021 rst_n=0 SHALL asynchronously force all outputs, including o_mem_req, to 0; a transaction in flight is abandoned.
REQ-022 The first grant SHALL be possible on the first rising edge after rst_n deasserts.

Structure
REQ-023 The state enum arb_state_t and default ARB_DATA_MAX_STREAK SHALL live in riscv_definitions.
REQ-024 The block SHALL be a single module with no sub-modules; the FSM, streak counter and response registers are inline.
REQ-025 Counter width SHALL be $clog2(DATA_MAX_STREAK+1).

Verification
REQ-026 Lone fetch at addr 0x100, ack 3 cycles after req, rdata 0x00500093 -> o_mem_addr=0x100, we=0; o_instr_ready pulses 1 cycle with o_instr_data=0x00500093.
REQ-027 Fetch and load of 0x2000 requested in the same IDLE cycle -> load granted first; fetch granted after the load's RESP; exactly 2 ready pulses, data first.
REQ-028 Store of 0xDEADBEEF, be=4'b0011, addr 0x40 -> o_mem_we=1, o_mem_be=0011, o_mem_wdata=0xDEADBEEF; o_data_ready pulses 1 cycle; o_data_rd unchanged.
REQ-029 Data requests back-to-back with fetch pending, DATA_MAX_STREAK=4 -> 5th grant is the fetch; counter reads 0 afterwards.
REQ-030 i_inst_kill pulsed during INST_WAIT, ack with rdata 0x12345678 -> no o_instr_ready pulse; o_instr_data keeps its old value; next fetch is served normally.
REQ-031 rst_n dropped mid DATA_WAIT -> o_mem_req=0 immediately (asynchronously); state IDLE; no ready pulse after release.
